// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and defaults for the SDRAM port arbiter.
// Slot states, download FIFO entry layout, download base address.
package sdram_port_arbiter_pkg;

  localparam int unsigned SLOT_LEN_DEF   = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam logic [24:0] DL_BASE_DEF    = 25'h0C000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DL_WR,
    ST_CPU_RD,
    ST_CPU_WR
  } arb_state_e;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

  function automatic logic [24:0] dl_sd_addr(
    input logic [24:0] base,
    input logic [13:0] off
  );
    return base + {11'd0, off};
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_dl_write_fifo.sv
// Download write FIFO: {addr,data} entries, wrap-bit pointers.
// Ports: clk, reset_n, push, pop, din, dout, empty, full.
module dl_write_fifo
  import sdram_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  dl_entry_t din,
  output dl_entry_t dout,
  output logic      empty,
  output logic      full
);

  localparam int unsigned AW = $clog2(DEPTH);

  dl_entry_t    mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;

  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Slot scheduler sharing one SDRAM port between download and CPU.
// In: clk, reset_n, dl_*, cpu_req/we/addr/din, sd_dout.
// Out: cpu_dout/ack/wait_n, sd_addr/din/we/oe, rom_loaded, fifo_ovf.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int unsigned SLOT_LEN   = SLOT_LEN_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [24:0] DL_BASE    = DL_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [13:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_wait_n,
  output logic [24:0] sd_addr,
  output logic [7:0]  sd_din,
  output logic        sd_we,
  output logic        sd_oe,
  input  logic [7:0]  sd_dout,
  output logic        rom_loaded,
  output logic        fifo_ovf
);

  localparam int unsigned SW = $clog2(SLOT_LEN);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_LEN - 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [24:0]   sd_addr_q, sd_addr_d;
  logic [7:0]    sd_din_q, sd_din_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          wait_n_q, wait_n_d;
  logic          armed_q, armed_d;
  logic          rl_q, rl_d;
  logic          ovf_q, ovf_d;
  logic          seen_q, seen_d;
  logic          dl_act_q;
  logic          slot_end, dl_go, cpu_go, cpu_busy, dl_rise;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  dl_entry_t     fifo_din, fifo_dout;

  // Grants take effect on the edge into slot 0 so a state
  // covers a whole slot; the three grant terms are exclusive.
  assign slot_end  = slot_q == SLOT_LAST;
  assign slot_d    = slot_end ? '0 : slot_q + SW'(1);
  assign dl_go     = !fifo_empty;
  assign cpu_go    = fifo_empty && cpu_req && armed_q && !dl_active;
  assign cpu_busy  = (state_q == ST_CPU_RD) || (state_q == ST_CPU_WR);
  assign dl_rise   = dl_active && !dl_act_q;
  assign fifo_pop  = slot_end && dl_go;
  assign fifo_push = dl_wr && (!fifo_full || fifo_pop);
  assign fifo_din  = '{addr: dl_addr, data: dl_data};

  dl_write_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    state_d   = state_q;
    sd_addr_d = sd_addr_q;
    sd_din_d  = sd_din_q;
    if (slot_end) begin
      unique case (1'b1)
        dl_go: begin
          state_d   = ST_DL_WR;
          sd_addr_d = dl_sd_addr(DL_BASE, fifo_dout.addr);
          sd_din_d  = fifo_dout.data;
        end
        cpu_go: begin
          state_d   = cpu_we ? ST_CPU_WR : ST_CPU_RD;
          sd_addr_d = {9'd0, cpu_addr};
          if (cpu_we) sd_din_d = cpu_din;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_ack_d  = slot_end && cpu_busy;
    cpu_dout_d = cpu_dout_q;
    if (slot_end && state_q == ST_CPU_RD) cpu_dout_d = sd_dout;
    // A request held past its ack stays disarmed: no reissue.
    armed_d  = !cpu_req || (armed_q && !(slot_end && cpu_go));
    wait_n_d = wait_n_q;
    if (cpu_ack_d || !cpu_req) wait_n_d = 1'b1;
    else if (armed_q)          wait_n_d = 1'b0;
    rl_d   = rl_q;
    ovf_d  = ovf_q;
    seen_d = seen_q;
    if (dl_rise) begin
      rl_d   = 1'b0;
      ovf_d  = 1'b0;
      seen_d = 1'b1;
    end else if (!dl_active && seen_q && fifo_empty &&
                 state_q != ST_DL_WR) begin
      rl_d = 1'b1;
    end
    if (dl_wr && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      sd_addr_q  <= '0;
      sd_din_q   <= '0;
      cpu_dout_q <= '0;
      cpu_ack_q  <= 1'b0;
      wait_n_q   <= 1'b1;
      armed_q    <= 1'b0;
      rl_q       <= 1'b0;
      ovf_q      <= 1'b0;
      seen_q     <= 1'b0;
      dl_act_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      sd_addr_q  <= sd_addr_d;
      sd_din_q   <= sd_din_d;
      cpu_dout_q <= cpu_dout_d;
      cpu_ack_q  <= cpu_ack_d;
      wait_n_q   <= wait_n_d;
      armed_q    <= armed_d;
      rl_q       <= rl_d;
      ovf_q      <= ovf_d;
      seen_q     <= seen_d;
      dl_act_q   <= dl_active;
    end
  end

  assign sd_we      = (state_q == ST_DL_WR) || (state_q == ST_CPU_WR);
  assign sd_oe      = state_q == ST_CPU_RD;
  assign sd_addr    = sd_addr_q;
  assign sd_din     = sd_din_q;
  assign cpu_dout   = cpu_dout_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_wait_n = wait_n_q;
  assign rom_loaded = rl_q;
  assign fifo_ovf   = ovf_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: queue-based reference model,
// scoreboard monitor, directed and random stimulus.
module tb_sdram_port_arbiter;

  localparam int SLOT_LEN = 8;
  localparam int DEPTH = 4;
  localparam logic [24:0] DL_BASE = 25'h0C000;

  logic clk = 1'b0;
  logic reset_n;
  logic dl_active, dl_wr;
  logic [13:0] dl_addr;
  logic [7:0] dl_data;
  logic cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0] cpu_din, cpu_dout;
  logic cpu_ack, cpu_wait_n;
  logic [24:0] sd_addr;
  logic [7:0] sd_din, sd_dout;
  logic sd_we, sd_oe, rom_loaded, fifo_ovf;

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .cpu_wait_n(cpu_wait_n),
    .sd_addr(sd_addr), .sd_din(sd_din),
    .sd_we(sd_we), .sd_oe(sd_oe), .sd_dout(sd_dout),
    .rom_loaded(rom_loaded), .fifo_ovf(fifo_ovf)
  );

  // SDRAM device model (64 KiB is enough for all addresses used)
  logic [7:0] sdmem [0:65535];
  initial for (int i = 0; i < 65536; i++) sdmem[i] = 8'h00;
  always @(posedge clk) if (sd_we) sdmem[sd_addr[15:0]] <= sd_din;
  assign sd_dout = sdmem[sd_addr[15:0]];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [13:0] a; logic [7:0] d; } dlb_t;
  typedef struct {
    logic we; logic oe; logic [24:0] addr; logic [7:0] din;
  } sdx_t;
  typedef struct { logic rd; logic [7:0] d; } ack_t;

  dlb_t dlq[$];
  sdx_t sdq[$];
  ack_t ackq[$];
  logic [7:0] ref_mem [int];

  int mslot = 0;
  int own = 0;  // 0 idle, 1 download, 2 cpu read, 3 cpu write
  bit m_armed = 0, m_rl = 0, m_ovf = 0, m_seen = 0, m_dlact = 0;
  logic [7:0] m_rdata = 8'h00;

  function automatic logic [7:0] mem_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  always @(posedge clk) begin : model
    bit eos;
    dlb_t b;
    int ad;
    if (!reset_n) begin
      dlq.delete(); sdq.delete(); ackq.delete();
      mslot = 0; own = 0;
      m_armed = 0; m_rl = 0; m_ovf = 0; m_seen = 0; m_dlact = 0;
    end else begin
      eos = (mslot == SLOT_LEN - 1);
      if (dl_active && !m_dlact) begin
        m_rl = 0; m_ovf = 0; m_seen = 1;
      end else if (!dl_active && m_seen && dlq.size() == 0 && own != 1)
        m_rl = 1;
      if (eos) begin
        if (own == 2) ackq.push_back('{1'b1, m_rdata});
        if (own == 3) ackq.push_back('{1'b0, 8'h00});
        if (dlq.size() != 0) begin
          b = dlq.pop_front();
          own = 1;
          ad = int'(DL_BASE + 25'(b.a));
          ref_mem[ad] = b.d;
          sdq.push_back('{1'b1, 1'b0, DL_BASE + 25'(b.a), b.d});
        end else if (cpu_req && m_armed && !dl_active) begin
          m_armed = 0;
          ad = int'(cpu_addr);
          sdq.push_back('{cpu_we, !cpu_we, {9'd0, cpu_addr}, cpu_din});
          if (cpu_we) begin
            own = 3;
            ref_mem[ad] = cpu_din;
          end else begin
            own = 2;
            m_rdata = mem_rd(ad);
          end
        end else own = 0;
      end
      if (!cpu_req) m_armed = 1;
      if (dl_wr) begin
        if (dlq.size() < DEPTH) dlq.push_back('{dl_addr, dl_data});
        else m_ovf = 1;
      end
      m_dlact = dl_active;
      mslot = eos ? 0 : mslot + 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic cur_we = 0, cur_oe = 0;

  always @(posedge clk) begin : monitor
    sdx_t e;
    ack_t a;
    #1;
    if (!reset_n) begin
      cur_we = 0; cur_oe = 0;
    end else begin
      if (mslot == 0) begin
        cur_we = sd_we; cur_oe = sd_oe;
        if (sdq.size() == 0) chk("sd_idle", {sd_we, sd_oe}, 0);
        else begin
          e = sdq.pop_front();
          chk("sd_we", sd_we, e.we);
          chk("sd_oe", sd_oe, e.oe);
          chk("sd_addr", sd_addr, e.addr);
          if (e.we) chk("sd_din", sd_din, e.din);
        end
      end else if (mslot == SLOT_LEN - 1) begin
        chk("sd_we_hold", sd_we, cur_we);
        chk("sd_oe_hold", sd_oe, cur_oe);
      end
      if (cpu_ack) begin
        if (ackq.size() == 0) chk("ack_unexp", cpu_ack, 0);
        else begin
          a = ackq.pop_front();
          if (a.rd) chk("cpu_dout", cpu_dout, a.d);
        end
      end else if (ackq.size() != 0) begin
        a = ackq.pop_front();
        chk("ack_missing", cpu_ack, 1);
      end
      chk("rom_loaded", rom_loaded, m_rl);
      chk("fifo_ovf", fifo_ovf, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cpu_access(input logic we, input logic [15:0] a,
                            input logic [7:0] d, input int hold);
    int n;
    @(negedge clk);
    cpu_we = we; cpu_addr = a; cpu_din = d; cpu_req = 1'b1;
    @(negedge clk);
    chk("wait_n_low", cpu_wait_n, 0);
    n = 0;
    while (!cpu_ack && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", cpu_ack, 1);
    chk("wait_n_ack", cpu_wait_n, 1);
    repeat (hold) begin
      @(negedge clk);
      chk("wait_n_hold", cpu_wait_n, 1);
    end
    cpu_req = 1'b0;
  endtask

  task automatic dl_byte(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
  endtask

  task automatic wait_loaded(input string nm);
    int n = 0;
    while (!rom_loaded && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, rom_loaded, 1);
  endtask

  initial begin : stim
    int n, acks;
    reset_n = 0; dl_active = 0; dl_wr = 0; dl_addr = '0; dl_data = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    repeat (3) @(negedge clk);
    chk("rst_sd_we", sd_we, 0);
    chk("rst_sd_oe", sd_oe, 0);
    chk("rst_wait_n", cpu_wait_n, 1);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_ovf", fifo_ovf, 0);
    reset_n = 1;
    repeat (20) @(negedge clk);

    // CPU write then read back
    cpu_access(1'b1, 16'h3000, 8'h5A, 0);
    cpu_access(1'b0, 16'h3000, 8'h00, 0);

    // download of four bytes, one per clock
    @(negedge clk) dl_active = 1'b1;
    for (int i = 0; i < 4; i++) dl_byte(14'(i), 8'(i));
    @(negedge clk) dl_wr = 1'b0;
    repeat (50) @(negedge clk);
    chk("t3_ovf", fifo_ovf, 0);

    // six-byte burst overflows a four-entry FIFO
    for (int i = 0; i < 6; i++) dl_byte(14'(16'h100 + i), 8'(8'hB0 + i));
    @(negedge clk) dl_wr = 1'b0;
    chk("t4_ovf", fifo_ovf, 1);
    repeat (60) @(negedge clk);
    dl_active = 1'b0;
    wait_loaded("t4_loaded");

    // download ends with two bytes queued; CPU read raised meanwhile
    fork
      begin
        @(negedge clk) dl_active = 1'b1;
        dl_byte(14'h200, 8'hA5);
        dl_byte(14'h201, 8'h5C);
        @(negedge clk);
        dl_wr = 1'b0; dl_active = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        cpu_access(1'b0, 16'hC201, 8'h00, 0);
      end
    join
    wait_loaded("t5_loaded");

    // request held past ack: single access
    cpu_access(1'b1, 16'h1234, 8'hC3, 3);
    repeat (10) @(negedge clk);

    // reset in the middle of a CPU read slot
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
    n = 0;
    while (!sd_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_grant", sd_oe, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6_async_oe", sd_oe, 0);
    chk("t6_async_we", sd_we, 0);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    repeat (30) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("t6_no_ack", acks, 0);

    // randomized mix of download traffic and CPU accesses
    fork
      begin
        @(negedge clk) dl_active = 1'b1;
        repeat (200) begin
          @(negedge clk);
          dl_wr = ($urandom_range(0, 5) == 0);
          dl_addr = 14'($urandom_range(0, 15));
          dl_data = 8'($urandom);
        end
        @(negedge clk);
        dl_wr = 1'b0; dl_active = 1'b0;
      end
      begin
        for (int k = 0; k < 12; k++) begin
          logic [15:0] ra;
          repeat ($urandom_range(0, 20)) @(negedge clk);
          if ($urandom_range(0, 1) == 1)
            ra = 16'hC000 + 16'($urandom_range(0, 15));
          else
            ra = 16'h3000 + 16'($urandom_range(0, 3));
          cpu_access(1'($urandom_range(0, 1)), ra, 8'($urandom),
                     int'($urandom_range(0, 2)));
        end
      end
    join
    wait_loaded("rand_loaded");
    repeat (40) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
